// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-port round-robin arbiter onto a single DDR user port
// Ethernet (p0) and host (p1) share the DDR controller; read data returns in order via a port-id tag FIFO.
module ddr_port_arbiter #(
   parameter int RD_TAG_DEPTH = 32,
   parameter int TAG_AW       = 5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_p0_wr_req,
   input  logic         i_p0_rd_req,
   input  logic [255:0] i_p0_wr_data,
   input  logic [31:0]  i_p0_wr_be,
   input  logic [31:0]  i_p0_wr_addr,
   input  logic [31:0]  i_p0_rd_addr,
   output logic         o_p0_wr_ack,
   output logic         o_p0_rd_ack,
   output logic [255:0] o_p0_rd_data,
   output logic         o_p0_rd_data_valid,
   input  logic         i_p1_wr_req,
   input  logic         i_p1_rd_req,
   input  logic [255:0] i_p1_wr_data,
   input  logic [31:0]  i_p1_wr_be,
   input  logic [31:0]  i_p1_wr_addr,
   input  logic [31:0]  i_p1_rd_addr,
   output logic         o_p1_wr_ack,
   output logic         o_p1_rd_ack,
   output logic [255:0] o_p1_rd_data,
   output logic         o_p1_rd_data_valid,
   output logic         o_ddr_wr_req,
   output logic         o_ddr_rd_req,
   output logic [255:0] o_ddr_wr_data,
   output logic [31:0]  o_ddr_wr_be,
   output logic [31:0]  o_ddr_wr_addr,
   output logic [31:0]  o_ddr_rd_addr,
   input  logic         i_ddr_wr_ack,
   input  logic         i_ddr_rd_ack,
   input  logic [255:0] i_ddr_rd_data,
   input  logic         i_ddr_rd_data_valid,
   output logic         o_tag_err
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACK} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rr;
   logic                r_port;
   logic                r_is_wr;
   logic [255:0]        r_wr_data;
   logic [31:0]         r_wr_be;
   logic [31:0]         r_wr_addr;
   logic [31:0]         r_rd_addr;
   logic [RD_TAG_DEPTH-1:0] r_tag_mem;
   logic [TAG_AW-1:0]   r_wptr;
   logic [TAG_AW-1:0]   r_rptr;
   logic [TAG_AW:0]     r_count;
   logic [255:0]        r_rd_data;
   logic [1:0]          r_rd_vld;
   logic                r_tag_err;

   logic w_full;
   logic w_elig0;
   logic w_elig1;
   logic w_win;
   logic w_win_wr;
   logic w_grant;
   logic w_ddr_ack;
   logic w_push;
   logic w_pop;
   logic w_pop_tag;

   assign w_full    = (r_count == (TAG_AW+1)'(RD_TAG_DEPTH));
   assign w_elig0   = i_p0_wr_req | (i_p0_rd_req & ~w_full);
   assign w_elig1   = i_p1_wr_req | (i_p1_rd_req & ~w_full);
   // Preferred port wins when eligible; otherwise the other port (only matters if it is eligible).
   assign w_win     = r_rr ? w_elig1 : ~w_elig0;
   assign w_win_wr  = w_win ? i_p1_wr_req : i_p0_wr_req;
   assign w_grant   = (r_state == S_IDLE) & (w_elig0 | w_elig1);
   assign w_ddr_ack = r_is_wr ? i_ddr_wr_ack : i_ddr_rd_ack;
   assign w_push    = (r_state == S_ISSUE) & ~r_is_wr & i_ddr_rd_ack;
   assign w_pop     = i_ddr_rd_data_valid & (r_count != '0);
   assign w_pop_tag = r_tag_mem[r_rptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_ddr_wr_req = 1'b0;
      o_ddr_rd_req = 1'b0;
      o_p0_wr_ack  = 1'b0;
      o_p0_rd_ack  = 1'b0;
      o_p1_wr_ack  = 1'b0;
      o_p1_rd_ack  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            o_ddr_wr_req = r_is_wr;
            o_ddr_rd_req = ~r_is_wr;
            if (w_ddr_ack) w_state_nxt = S_ACK;
         end
         S_ACK: begin
            o_p0_wr_ack = ~r_port & r_is_wr;
            o_p0_rd_ack = ~r_port & ~r_is_wr;
            o_p1_wr_ack = r_port & r_is_wr;
            o_p1_rd_ack = r_port & ~r_is_wr;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr      <= 1'b0;
         r_port    <= 1'b0;
         r_is_wr   <= 1'b0;
         r_wr_data <= '0;
         r_wr_be   <= '0;
         r_wr_addr <= '0;
         r_rd_addr <= '0;
      end else if (w_grant) begin
         r_rr    <= ~w_win;
         r_port  <= w_win;
         r_is_wr <= w_win_wr;
         if (w_win_wr) begin
            r_wr_data <= w_win ? i_p1_wr_data : i_p0_wr_data;
            r_wr_be   <= w_win ? i_p1_wr_be   : i_p0_wr_be;
            r_wr_addr <= w_win ? i_p1_wr_addr : i_p0_wr_addr;
         end else begin
            r_rd_addr <= w_win ? i_p1_rd_addr : i_p0_rd_addr;
         end
      end
   end

   // Tag storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge i_clk) begin
      if (w_push) r_tag_mem[r_wptr] <= r_port;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_rd_data <= '0;
         r_rd_vld  <= 2'b00;
         r_tag_err <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push & ~w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop & ~w_push) begin
            r_count <= r_count - 1'b1;
         end
         r_rd_data   <= i_ddr_rd_data;
         r_rd_vld[0] <= w_pop & ~w_pop_tag;
         r_rd_vld[1] <= w_pop & w_pop_tag;
         if (i_ddr_rd_data_valid & (r_count == '0)) r_tag_err <= 1'b1;
      end
   end

   assign o_ddr_wr_data      = r_wr_data;
   assign o_ddr_wr_be        = r_wr_be;
   assign o_ddr_wr_addr      = r_wr_addr;
   assign o_ddr_rd_addr      = r_rd_addr;
   assign o_p0_rd_data       = r_rd_data;
   assign o_p1_rd_data       = r_rd_data;
   assign o_p0_rd_data_valid = r_rd_vld[0];
   assign o_p1_rd_data_valid = r_rd_vld[1];
   assign o_tag_err          = r_tag_err;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - self-checking bench for ddr_port_arbiter
// Transaction-level reference model plus directed scenarios and a randomized traffic phase.
module tb_ddr_port_arbiter;

   logic         clk;
   logic         i_rst;
   logic [1:0]   wr_req, rd_req;
   logic [255:0] wr_data [2];
   logic [31:0]  wr_be [2];
   logic [31:0]  wr_addr [2];
   logic [31:0]  rd_addr [2];
   logic [1:0]   wr_ack, rd_ack, rv;
   logic [255:0] rdata [2];
   logic         o_ddr_wr_req, o_ddr_rd_req;
   logic [255:0] o_ddr_wr_data;
   logic [31:0]  o_ddr_wr_be, o_ddr_wr_addr, o_ddr_rd_addr;
   logic         ddr_wr_ack, ddr_rd_ack, ddr_dv;
   logic [255:0] ddr_rdata;
   logic         o_tag_err;

   int n_checks = 0;
   int n_fail   = 0;

   ddr_port_arbiter #(.RD_TAG_DEPTH(32), .TAG_AW(5)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_p0_wr_req(wr_req[0]), .i_p0_rd_req(rd_req[0]), .i_p0_wr_data(wr_data[0]),
      .i_p0_wr_be(wr_be[0]), .i_p0_wr_addr(wr_addr[0]), .i_p0_rd_addr(rd_addr[0]),
      .o_p0_wr_ack(wr_ack[0]), .o_p0_rd_ack(rd_ack[0]), .o_p0_rd_data(rdata[0]),
      .o_p0_rd_data_valid(rv[0]),
      .i_p1_wr_req(wr_req[1]), .i_p1_rd_req(rd_req[1]), .i_p1_wr_data(wr_data[1]),
      .i_p1_wr_be(wr_be[1]), .i_p1_wr_addr(wr_addr[1]), .i_p1_rd_addr(rd_addr[1]),
      .o_p1_wr_ack(wr_ack[1]), .o_p1_rd_ack(rd_ack[1]), .o_p1_rd_data(rdata[1]),
      .o_p1_rd_data_valid(rv[1]),
      .o_ddr_wr_req(o_ddr_wr_req), .o_ddr_rd_req(o_ddr_rd_req), .o_ddr_wr_data(o_ddr_wr_data),
      .o_ddr_wr_be(o_ddr_wr_be), .o_ddr_wr_addr(o_ddr_wr_addr), .o_ddr_rd_addr(o_ddr_rd_addr),
      .i_ddr_wr_ack(ddr_wr_ack), .i_ddr_rd_ack(ddr_rd_ack), .i_ddr_rd_data(ddr_rdata),
      .i_ddr_rd_data_valid(ddr_dv), .o_tag_err(o_tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one transaction in flight, a queue of owning ports for outstanding reads.
   bit           m_rr, m_busy, m_acking, m_cur_wr, m_cur_port, m_err, m_w, m_t;
   bit           m_q [$];
   int           m_sz;
   logic [1:0]   m_e, m_rv;
   logic [255:0] m_rdata, m_cur_data;
   logic [31:0]  m_cur_addr, m_cur_be;

   always @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         m_rr = 0; m_busy = 0; m_acking = 0; m_cur_wr = 0; m_cur_port = 0; m_err = 0;
         m_q.delete(); m_rv = 2'b00; m_rdata = '0;
      end else begin
         m_sz = m_q.size();
         m_rv = 2'b00;
         if (ddr_dv) begin
            if (m_sz == 0) m_err = 1;
            else begin
               m_t = m_q.pop_front();
               m_rv[m_t] = 1'b1;
            end
         end
         m_rdata = ddr_rdata;
         if (m_acking) begin
            m_acking = 0;
         end else if (m_busy) begin
            if (m_cur_wr ? ddr_wr_ack : ddr_rd_ack) begin
               m_busy = 0;
               m_acking = 1;
               if (!m_cur_wr) m_q.push_back(m_cur_port);
            end
         end else begin
            for (int n = 0; n < 2; n++) m_e[n] = wr_req[n] || (rd_req[n] && m_sz < 32);
            if (m_e != 2'b00) begin
               m_w        = m_e[m_rr] ? m_rr : !m_rr;
               m_busy     = 1;
               m_cur_port = m_w;
               m_cur_wr   = wr_req[m_w];
               m_cur_addr = m_cur_wr ? wr_addr[m_w] : rd_addr[m_w];
               m_cur_data = wr_data[m_w];
               m_cur_be   = wr_be[m_w];
               m_rr       = !m_w;
            end
         end
      end
   end

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic cmp_cycle();
      chk("ddr_wr_req", o_ddr_wr_req, m_busy && m_cur_wr);
      chk("ddr_rd_req", o_ddr_rd_req, m_busy && !m_cur_wr);
      for (int n = 0; n < 2; n++) begin
         chk("wr_ack", wr_ack[n], m_acking && m_cur_wr && m_cur_port == n);
         chk("rd_ack", rd_ack[n], m_acking && !m_cur_wr && m_cur_port == n);
         chk("rd_valid", rv[n], m_rv[n]);
         chk("rd_data", rdata[n], m_rdata);
      end
      chk("tag_err", o_tag_err, m_err);
      if (m_busy && m_cur_wr) begin
         chk("ddr_wr_addr", o_ddr_wr_addr, m_cur_addr);
         chk("ddr_wr_data", o_ddr_wr_data, m_cur_data);
         chk("ddr_wr_be", o_ddr_wr_be, m_cur_be);
      end
      if (m_busy && !m_cur_wr) chk("ddr_rd_addr", o_ddr_rd_addr, m_cur_addr);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step();
      #2 i_rst = 1'b1;
      step();
      i_rst = 1'b0;
   endtask

   task automatic wait_req(input bit wr, input string nm);
      for (int i = 0; i < 20; i++) begin
         step();
         if (wr ? o_ddr_wr_req : o_ddr_rd_req) break;
      end
      chk(nm, wr ? o_ddr_wr_req : o_ddr_rd_req, 1);
   endtask

   initial begin
      int g0, g1, cnt, pending;
      bit seen_rd, got;
      int order [$];
      i_rst = 1'b1;
      wr_req = 0; rd_req = 0; ddr_wr_ack = 0; ddr_rd_ack = 0; ddr_dv = 0; ddr_rdata = '0;
      for (int n = 0; n < 2; n++) begin
         wr_data[n] = '0; wr_be[n] = '0; wr_addr[n] = '0; rd_addr[n] = '0;
      end
      fork
         forever begin
            @(negedge clk);
            cmp_cycle();
         end
      join_none

      // Reset state
      step();
      chk("rst_wr_req", o_ddr_wr_req, 0);
      chk("rst_rd_req", o_ddr_rd_req, 0);
      chk("rst_acks", {wr_ack, rd_ack, rv}, 0);
      chk("rst_addr", {o_ddr_wr_addr, o_ddr_rd_addr, o_ddr_wr_be}, 0);
      chk("rst_tag_err", o_tag_err, 0);
      step();
      i_rst = 1'b0;

      // Port 0 write, DDR acks after two request cycles
      wr_req[0] = 1; wr_addr[0] = 32'h100; wr_be[0] = 32'hFFFF_FFFF;
      wr_data[0] = {8{32'hDEAD_BEEF}};
      step();
      chk("t2_req1", o_ddr_wr_req, 1);
      chk("t2_addr", o_ddr_wr_addr, 32'h100);
      chk("t2_be", o_ddr_wr_be, 32'hFFFF_FFFF);
      chk("t2_data", o_ddr_wr_data, {8{32'hDEAD_BEEF}});
      step();
      chk("t2_req2", o_ddr_wr_req, 1);
      ddr_wr_ack = 1;
      step();
      ddr_wr_ack = 0;
      chk("t2_req_low", o_ddr_wr_req, 0);
      chk("t2_ack", wr_ack[0], 1);
      wr_req[0] = 0;
      step();
      chk("t2_ack_once", wr_ack[0], 0);
      chk("t2_no_regrant", o_ddr_wr_req, 0);
      step();
      chk("t2_no_regrant2", o_ddr_wr_req, 0);

      // Both ports hold rd_req for six reads each
      do_reset();
      rd_addr[0] = 32'h1000; rd_addr[1] = 32'h2000;
      g0 = 0; g1 = 0;
      rd_req = 2'b11;
      for (int c = 0; c < 100 && (g0 < 6 || g1 < 6); c++) begin
         step();
         ddr_rd_ack = o_ddr_rd_req;
         if (rd_ack[0]) begin order.push_back(0); g0++; if (g0 == 6) rd_req[0] = 0; end
         if (rd_ack[1]) begin order.push_back(1); g1++; if (g1 == 6) rd_req[1] = 0; end
      end
      ddr_rd_ack = 0;
      chk("t3_grants", order.size(), 12);
      foreach (order[i]) chk("t3_order", order[i], i % 2);
      for (int k = 0; k < 12; k++) begin
         ddr_dv = 1;
         ddr_rdata = 256'(32'hA0 + k);
         step();
         chk("t3_route", rv[k % 2], 1);
         chk("t3_other", rv[1 - (k % 2)], 0);
         chk("t3_beat", rdata[k % 2], 256'(32'hA0 + k));
      end
      ddr_dv = 0;

      // Port 1 write and read together: write first
      order.delete();
      wr_req[1] = 1; rd_req[1] = 1; wr_addr[1] = 32'h44; rd_addr[1] = 32'h88;
      for (int c = 0; c < 30 && (wr_req[1] || rd_req[1]); c++) begin
         step();
         ddr_wr_ack = o_ddr_wr_req;
         ddr_rd_ack = o_ddr_rd_req;
         if (wr_ack[1]) begin order.push_back(1); wr_req[1] = 0; end
         if (rd_ack[1]) begin order.push_back(0); rd_req[1] = 0; end
      end
      ddr_wr_ack = 0; ddr_rd_ack = 0;
      chk("t4_count", order.size(), 2);
      if (order.size() == 2) begin
         chk("t4_first_wr", order[0], 1);
         chk("t4_then_rd", order[1], 0);
      end

      // 32 outstanding reads: 33rd held off, writes continue
      do_reset();
      cnt = 0;
      rd_req[1] = 1;
      for (int c = 0; c < 300 && cnt < 32; c++) begin
         step();
         ddr_rd_ack = o_ddr_rd_req;
         if (rd_ack[1]) cnt++;
      end
      ddr_rd_ack = 0;
      chk("t5_32_reads", cnt, 32);
      wr_req[0] = 1; wr_addr[0] = 32'h500;
      seen_rd = 0; got = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         ddr_wr_ack = o_ddr_wr_req;
         if (o_ddr_rd_req) seen_rd = 1;
         if (wr_ack[0]) begin got = 1; wr_req[0] = 0; end
      end
      ddr_wr_ack = 0;
      chk("t5_read_blocked", seen_rd, 0);
      chk("t5_write_granted", got, 1);
      ddr_dv = 1; ddr_rdata = 256'h55;
      step();
      ddr_dv = 0;
      chk("t5_free_slot_beat", rv[1], 1);
      got = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         ddr_rd_ack = o_ddr_rd_req;
         if (rd_ack[1]) begin got = 1; rd_req[1] = 0; end
      end
      ddr_rd_ack = 0;
      chk("t5_33rd_issued", got, 1);
      cnt = 0;
      for (int i = 0; i < 31; i++) begin
         ddr_dv = 1; ddr_rdata = 256'(i);
         step();
         cnt += int'(rv[1]);
      end
      ddr_dv = 0;
      chk("t5_drain", cnt, 31);

      // Simultaneous push and pop with one outstanding, then underflow
      rd_req[0] = 1; rd_addr[0] = 32'h600;
      wait_req(0, "t6_rd_issue");
      ddr_rd_ack = 1; ddr_dv = 1; ddr_rdata = 256'hC3;
      step();
      ddr_rd_ack = 0; ddr_dv = 0;
      chk("t6_pop_p1", rv[1], 1);
      chk("t6_not_p0", rv[0], 0);
      chk("t6_ack", rd_ack[0], 1);
      rd_req[0] = 0;
      step();
      ddr_dv = 1;
      step();
      ddr_dv = 0;
      chk("t6_pop_p0", rv[0], 1);
      ddr_dv = 1;
      step();
      ddr_dv = 0;
      chk("t6_underflow_nov", rv, 0);
      chk("t6_tag_err", o_tag_err, 1);
      step();
      chk("t6_tag_err_sticky", o_tag_err, 1);

      // Reset during ISSUE
      do_reset();
      chk("t7_err_cleared", o_tag_err, 0);
      rd_req[1] = 1;
      wait_req(0, "t7_rd_issue");
      ddr_rd_ack = 1;
      step();
      ddr_rd_ack = 0;
      rd_req[1] = 0;
      wr_req[0] = 1; wr_addr[0] = 32'h200; wr_data[0] = {8{32'h1234_5678}};
      wait_req(1, "t7_wr_issue");
      #2 i_rst = 1'b1;
      #1;
      chk("t7_rst_wr_req", o_ddr_wr_req, 0);
      chk("t7_rst_addr", o_ddr_wr_addr, 0);
      chk("t7_rst_data", o_ddr_wr_data, 0);
      chk("t7_rst_acks", {wr_ack, rd_ack, rv}, 0);
      wr_req[0] = 0;
      step();
      i_rst = 1'b0;
      step();
      ddr_dv = 1;
      step();
      ddr_dv = 0;
      chk("t7_flushed_nov", rv, 0);
      chk("t7_stale_err", o_tag_err, 1);
      do_reset();
      wr_addr[0] = 32'h300; wr_addr[1] = 32'h400;
      wr_req = 2'b11;
      wait_req(1, "t7_rr_issue");
      chk("t7_rr_p0_first", o_ddr_wr_addr, 32'h300);
      wr_req = 2'b00;
      do_reset();

      // Randomized traffic
      pending = 0;
      for (int c = 0; c < 4000; c++) begin
         step();
         for (int n = 0; n < 2; n++) begin
            if (wr_ack[n]) wr_req[n] = 0;
            else if (!wr_req[n] && $urandom_range(3) == 0) begin
               wr_req[n] = 1; wr_addr[n] = $urandom; wr_be[n] = $urandom;
               for (int j = 0; j < 8; j++) wr_data[n][j*32 +: 32] = $urandom;
            end
            if (rd_ack[n]) rd_req[n] = 0;
            else if (!rd_req[n] && $urandom_range(3) == 0) begin
               rd_req[n] = 1; rd_addr[n] = $urandom;
            end
         end
         ddr_dv = (pending > 0) && ($urandom_range(2) == 0);
         if (ddr_dv) pending--;
         for (int j = 0; j < 8; j++) ddr_rdata[j*32 +: 32] = $urandom;
         ddr_wr_ack = o_ddr_wr_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         ddr_rd_ack = o_ddr_rd_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         if (o_ddr_rd_req && ddr_rd_ack) pending++;
      end
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
